// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared widths, FSM state encoding and most-negative helper for the divider
package seq_divider_pkg;
  localparam int WN_DEF = 16;
  localparam int WD_DEF = 8;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  // Bit pattern of -2^(w-1) for a w-bit signed value, zero-extended to 32 bits.
  function automatic logic [31:0] most_neg(input int w);
    return 32'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one combinational restoring-division step (shift in a bit, trial subtract)
//   pr      in   WD+1  partial remainder before the step
//   nbit    in   1     next dividend bit, MSB first
//   dmag    in   WD    divisor magnitude
//   pr_next out  WD+1  partial remainder after the step
//   qbit    out  1     quotient bit produced by the step
module seq_divider_div_step #(
  parameter int WD = 8
) (
  input  logic [WD:0]   pr,
  input  logic          nbit,
  input  logic [WD-1:0] dmag,
  output logic [WD:0]   pr_next,
  output logic          qbit
);
  logic [WD+1:0] sh;
  assign sh = {pr, nbit};
  assign qbit = sh >= (WD+2)'(dmag);
  // The restored value is always below dmag, so it fits back into WD+1 bits.
  assign pr_next = (WD+1)'(qbit ? sh - (WD+2)'(dmag) : sh);
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential signed radix-2 restoring divider with valid/ready handshake
//   clk        in   1   clock
//   reset      in   1   asynchronous active-high reset
//   in_valid   in   1   operands presented
//   in_ready   out  1   idle, can accept
//   dividend   in   WN  signed dividend
//   divisor    in   WD  signed divisor
//   out_valid  out  1   result presented, held until taken
//   out_ready  in   1   consumer takes result
//   quotient   out  WN  signed quotient (truncated toward zero)
//   remainder  out  WD  signed remainder (sign of dividend)
//   div_zero   out  1   divisor was zero
//   ovf        out  1   quotient not representable (most-negative / -1)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WD = WD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);
  localparam int CW = $clog2(WN);
  localparam logic [31:0] MN = most_neg(WN);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WN-1:0] nq;
  logic [WD:0] pr, pr_next;
  logic [WD-1:0] dmag;
  logic neg_n, neg_q, qbit;
  // nq starts as the dividend magnitude; each step shifts its MSB out and a quotient bit in,
  // so after WN steps it holds the quotient magnitude.
  seq_divider_div_step #(.WD(WD)) u_step (
    .pr(pr),
    .nbit(nq[WN-1]),
    .dmag(dmag),
    .pr_next(pr_next),
    .qbit(qbit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      nq <= '0;
      pr <= '0;
      dmag <= '0;
      neg_n <= 1'b0;
      neg_q <= 1'b0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
      ovf <= 1'b0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            in_ready <= 1'b0;
            neg_n <= dividend[WN-1];
            neg_q <= dividend[WN-1] ^ divisor[WD-1];
            nq <= dividend[WN-1] ? -dividend : dividend;
            dmag <= divisor[WD-1] ? -divisor : divisor;
            pr <= '0;
            cnt <= CW'(WN - 1);
            if (divisor == '0) begin
              state <= DONE;
              out_valid <= 1'b1;
              div_zero <= 1'b1;
              ovf <= 1'b0;
              quotient <= '1;
              remainder <= '0;
            end else
              state <= CALC;
          end
        CALC: begin
          nq <= {nq[WN-2:0], qbit};
          pr <= pr_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient <= neg_q ? -nq : nq;
          remainder <= neg_n ? -pr[WD-1:0] : pr[WD-1:0];
          // A positive quotient of magnitude 2^(WN-1) only arises from most-negative / -1.
          ovf <= !neg_q && nq == MN[WN-1:0];
          div_zero <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_zero, ovf;
  logic [15:0] dividend = '0, quotient;
  logic [7:0] divisor = '0, remainder;
  int tests = 0, fails = 0;
  typedef struct {
    logic [15:0] q;
    logic [7:0] r;
    logic dz;
    logic ov;
  } exp_t;
  exp_t expq[$];
  seq_divider dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic signed [15:0] a, input logic signed [7:0] b);
    exp_t e;
    int ai, bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      e.q = 16'hFFFF; e.r = 8'h00; e.dz = 1'b1; e.ov = 1'b0;
    end else begin
      e.q = 16'(ai / bi); e.r = 8'(ai % bi); e.dz = 1'b0;
      e.ov = ai == -32768 && bi == -1;
    end
    return e;
  endfunction
  always @(negedge clk)
    if (!reset && out_valid) begin
      if (expq.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        check("quotient", quotient, expq[0].q);
        check("remainder", remainder, expq[0].r);
        check("div_zero", div_zero, expq[0].dz);
        check("ovf", ovf, expq[0].ov);
        check("in_ready_in_done", in_ready, 0);
        if (out_ready) void'(expq.pop_front());
      end
    end
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_timeout", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    e = model(a, b);
    expq.push_back(e);
    n = 1;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom); dividend = 16'($urandom); divisor = 8'($urandom);
      @(posedge clk); #1; n++;
    end
    check("latency", n, b == 8'h00 ? 1 : 18);
    repeat (hold) begin
      in_valid = 1'($urandom); dividend = 16'($urandom); divisor = 8'($urandom);
      check("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("taken_out_valid", out_valid, 0);
    check("taken_in_ready", in_ready, 1);
    check("retained_quotient", quotient, e.q);
  endtask
  int da[7] = '{1000, -1000, 1000, 32767, -32768, -32768, 500};
  int db[7] = '{7, 7, -7, -128, -1, 1, 0};
  logic [15:0] lq[7] = '{16'd142, 16'hFF72, 16'hFF72, 16'hFF01, 16'h8000, 16'h8000, 16'hFFFF};
  logic [7:0] lr[7] = '{8'd6, 8'hFA, 8'h06, 8'h7F, 8'h00, 8'h00, 8'h00};
  logic ldz[7] = '{0, 0, 0, 0, 0, 0, 1};
  logic lov[7] = '{0, 0, 0, 0, 1, 0, 0};
  initial begin
    exp_t e;
    logic [15:0] ra;
    logic [7:0] rb;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_zero, ovf}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      e = model(16'(da[i]), 8'(db[i]));
      check("model_q", e.q, lq[i]);
      check("model_r", e.r, lr[i]);
      check("model_flags", {e.dz, e.ov}, {ldz[i], lov[i]});
      do_op(16'(da[i]), 8'(db[i]), 0);
      check("lit_quotient", quotient, lq[i]);
      check("lit_remainder", remainder, lr[i]);
      check("lit_flags", {div_zero, ovf}, {ldz[i], lov[i]});
    end
    do_op(16'd1000, 8'd7, 10);
    check("held_lit_quotient", quotient, 16'd142);
    dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_out_valid", out_valid, 0);
    check("async_quotient", quotient, 0);
    check("async_remainder", remainder, 0);
    check("async_flags", {div_zero, ovf}, 0);
    expq.delete();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    do_op(16'd100, 8'd3, 0);
    check("after_rst_quotient", quotient, 16'd33);
    check("after_rst_remainder", remainder, 8'd1);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0: rb = 8'h00;
        1: rb = 8'hFF;
        2: rb = 8'h80;
        3: rb = 8'h01;
        default: rb = 8'($urandom);
      endcase
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
